instr_loader: RTL and testbench

- Producer end of the 12-bit instruction interface consumed by the processor's scheduler.
- Accepts nibble-serial program words from chip pins and assembles them into 12-bit instructions.
- Rejects instructions that would make the scheduler fault, then stores the rest in a small program buffer.
- On start, resets the processor and replays the stored program one instruction per cycle.

---
 rtl/instr_loader_pkg.sv | 47 ++++
 rtl/instr_buffer.sv | 29 ++
 rtl/instr_loader.sv | 143 ++++++++++++++
 tb/tb_instr_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader and the scheduler.
// Holds the state encoding, the field map and the slot-dependency helper.
package instr_loader_pkg;

    localparam int DEPTH          = 8;
    localparam int INSTR_W        = 12;
    localparam int NIB_W          = 4;
    localparam int NIBS_PER_INSTR = INSTR_W / NIB_W;
    localparam int AW             = $clog2(DEPTH);
    localparam int CW             = AW + 1;

    // Field bit positions, shared with the scheduler
    localparam int OP0_MSB     = 11;
    localparam int OP0_SRC_LSB = 8;
    localparam int OP1_MSB     = 7;
    localparam int OP1_SRC_LSB = 4;
    localparam int IMM0_BIT    = 3;
    localparam int IMM1_BIT    = 2;
    localparam int ALU_MSB     = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        ISSUE,
        DONE
    } state_e;

    typedef struct packed {
        logic [3:0] op0;
        logic [3:0] op1;
        logic       use_imm_0;
        logic       use_imm_1;
        logic [1:0] alu_op;
    } instr_t;

    // An operand is safe when it is immediate or names a PE whose
    // slot is strictly earlier than the slot being written.
    function automatic logic src_ok(
        input logic          use_imm,
        input logic [AW-1:0] src,
        input logic [CW-1:0] slot
    );
        return use_imm || ({1'b0, src} < slot);
    endfunction

endpackage

// File: rtl/instr_buffer.sv
// DEPTH x INSTR_W program register file: one write port, one async read.
// Ports: clock, reset_n, we_i/waddr_i/wdata_i write, raddr_i/rdata_o read.
module instr_buffer
    import instr_loader_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_loader.sv
// Assembles nibble-serial words, filters scheduler-unsafe ones, and replays
// the stored program. Ports: nibble load side, start, instr/proc_reset out.
module instr_loader
    import instr_loader_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NIB_W-1:0]   nib_in,
    input  logic               nib_valid,
    input  logic               load_mode,
    input  logic               start,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               proc_reset,
    output logic               busy,
    output logic               done,
    output logic [CW-1:0]      load_count,
    output logic               load_err
);

    localparam logic [1:0]    LAST_NIB = 2'(NIBS_PER_INSTR - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    state_e                     state_q;
    logic [1:0]                 nib_cnt_q;
    logic [INSTR_W-NIB_W-1:0]   asm_q;
    logic [CW-1:0]              rd_q;
    logic [CW-1:0]              cnt_q;
    logic                       err_q;
    logic [INSTR_W-1:0]         out_q;
    logic                       valid_q;
    logic                       prst_q;
    logic                       busy_q;
    logic                       done_q;

    instr_t                     word_w;
    logic                       last_nib_w;
    logic                       accept_w;
    logic [INSTR_W-1:0]         rd_data_w;

    assign word_w     = instr_t'({asm_q, nib_in});
    assign last_nib_w = (state_q == LOAD) && load_mode && nib_valid
                        && (nib_cnt_q == LAST_NIB);
    assign accept_w   = last_nib_w && (cnt_q != FULL)
                        && src_ok(word_w.use_imm_0, word_w.op0[AW-1:0], cnt_q)
                        && src_ok(word_w.use_imm_1, word_w.op1[AW-1:0], cnt_q);

    instr_buffer u_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .we_i    (accept_w),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (word_w),
        .raddr_i (rd_q[AW-1:0]),
        .rdata_o (rd_data_w)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            nib_cnt_q <= '0;
            asm_q     <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            prst_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            prst_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_mode) begin
                        state_q   <= LOAD;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        nib_cnt_q <= '0;
                    end else if (start && cnt_q != '0) begin
                        state_q <= ARM;
                        prst_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        rd_q    <= '0;
                    end
                end
                LOAD: begin
                    // Leaving drops any partial word; stored entries stay.
                    if (!load_mode) begin
                        state_q   <= IDLE;
                        nib_cnt_q <= '0;
                    end else if (nib_valid) begin
                        if (nib_cnt_q == LAST_NIB) begin
                            nib_cnt_q <= '0;
                            if (accept_w) begin
                                cnt_q <= cnt_q + 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            asm_q     <= {asm_q[INSTR_W-2*NIB_W-1:0], nib_in};
                            nib_cnt_q <= nib_cnt_q + 1'b1;
                        end
                    end
                end
                ARM: begin
                    state_q <= ISSUE;
                    out_q   <= rd_data_w;
                    valid_q <= 1'b1;
                    rd_q    <= rd_q + 1'b1;
                end
                ISSUE: begin
                    if (rd_q == cnt_q) begin
                        state_q <= DONE;
                        out_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        out_q <= rd_data_w;
                        rd_q  <= rd_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_out   = out_q;
    assign instr_valid = valid_q;
    assign proc_reset  = prst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign load_count  = cnt_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomised scoreboard bench for instr_loader.
// Reference model: a queue of accepted words plus a sticky error flag.
module tb_instr_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        load_mode;
    logic        start;
    logic [11:0] instr_out;
    logic        instr_valid;
    logic        proc_reset;
    logic        busy;
    logic        done;
    logic [3:0]  load_count;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    logic [11:0] model_q[$];
    bit          model_err;
    logic [11:0] exp_q[$];

    instr_loader dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .nib_in      (nib_in),
        .nib_valid   (nib_valid),
        .load_mode   (load_mode),
        .start       (start),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .proc_reset  (proc_reset),
        .busy        (busy),
        .done        (done),
        .load_count  (load_count),
        .load_err    (load_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every issued instruction must be the next scoreboard entry.
    always @(negedge clock) begin
        if (reset_n) begin
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", int'(instr_out), -1);
                end else begin
                    check("instr_out", int'(instr_out), int'(exp_q.pop_front()));
                end
            end else if (instr_out != 12'h000) begin
                check("idle_instr_out", int'(instr_out), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enter_load();
        load_mode = 1'b1;
        tick();
        model_q.delete();
        model_err = 1'b0;
        check("entry_count", int'(load_count), 0);
        check("entry_err", int'(load_err), 0);
    endtask

    task automatic exit_load();
        load_mode = 1'b0;
        tick();
    endtask

    task automatic send_nib(input logic [3:0] n);
        repeat ($urandom_range(0, 2)) tick();
        nib_valid = 1'b1;
        nib_in    = n;
        tick();
        nib_valid = 1'b0;
        nib_in    = 4'($urandom);
    endtask

    task automatic send_word(input logic [11:0] w);
        int  s;
        bit  rej;
        send_nib(w[11:8]);
        send_nib(w[7:4]);
        send_nib(w[3:0]);
        s   = model_q.size();
        rej = (s == 8)
              || (!w[3] && int'(w[10:8]) >= s)
              || (!w[2] && int'(w[6:4]) >= s);
        if (rej) model_err = 1'b1;
        else     model_q.push_back(w);
        check("load_count", int'(load_count), model_q.size());
        check("load_err", int'(load_err), int'(model_err));
    endtask

    task automatic run(input bit disturb);
        int lc;
        int k;
        bit got;
        lc = model_q.size();
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("arm_proc_reset", int'(proc_reset), 1);
        check("arm_busy", int'(busy), 1);
        check("arm_no_valid", int'(instr_valid), 0);
        if (disturb) begin
            start     = 1'b1;
            load_mode = 1'b1;
            nib_valid = 1'b1;
        end
        tick();
        check("first_valid", int'(instr_valid), 1);
        check("proc_reset_pulse", int'(proc_reset), 0);
        k   = 0;
        got = 1'b0;
        while (k < 30 && !got) begin
            tick();
            k++;
            if (k == 1) begin
                start     = 1'b0;
                load_mode = 1'b0;
                nib_valid = 1'b0;
            end
            if (done) got = 1'b1;
        end
        if (!got) check("done_timeout", 0, 1);
        else      check("done_latency", k, lc);
        check("done_busy", int'(busy), 0);
        check("all_issued", exp_q.size(), 0);
        tick();
        check("done_pulse", int'(done), 0);
        check("program_kept", int'(load_count), lc);
    endtask

    initial begin
        logic [11:0] w;
        reset_n   = 1'b0;
        nib_in    = 4'h0;
        nib_valid = 1'b0;
        load_mode = 1'b0;
        start     = 1'b0;
        model_err = 1'b0;
        #12;
        check("rst_valid", int'(instr_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(load_count), 0);
        check("rst_proc_reset", int'(proc_reset), 0);
        reset_n = 1'b1;
        tick();

        // Directed program, all immediate
        enter_load();
        send_word(12'hA5C);
        send_word(12'h12D);
        send_word(12'h34E);
        exit_load();
        run(1'b0);

        // Slot-0 dependency rejected, then immediate word accepted
        enter_load();
        send_word(12'h000);
        send_word(12'h10C);
        exit_load();
        check("dep_err_kept", int'(load_err), 1);
        run(1'b0);

        // Overfill: the ninth word is rejected
        enter_load();
        for (int i = 0; i < 9; i++) begin
            w = 12'($urandom);
            w[3:2] = 2'b11;
            send_word(w);
        end
        exit_load();
        check("full_count", int'(load_count), 8);
        check("full_err", int'(load_err), 1);
        run(1'b0);

        // Partial word dropped on exit, then a clean reload
        enter_load();
        send_word(12'hA5C);
        send_nib(4'h7);
        send_nib(4'h1);
        exit_load();
        check("partial_count", int'(load_count), 1);
        enter_load();
        send_word(12'h23C);
        exit_load();
        run(1'b0);

        // Inputs during a run are ignored; second start replays
        enter_load();
        send_word(12'hA5C);
        send_word(12'h12D);
        send_word(12'h34E);
        exit_load();
        run(1'b1);
        run(1'b0);

        // Random programs with dependency-prone words
        for (int p = 0; p < 6; p++) begin
            enter_load();
            for (int i = 0; i < int'($urandom_range(1, 11)); i++) begin
                w = 12'($urandom);
                if ($urandom_range(0, 1) == 1) w[3:2] = 2'b11;
                send_word(w);
            end
            exit_load();
            if (model_q.size() > 0) run(1'b0);
        end

        // load_mode beats start in IDLE
        load_mode = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("lm_wins_no_prst", int'(proc_reset), 0);
        check("lm_wins_cleared", int'(load_count), 0);
        model_q.delete();
        model_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 12'($urandom);
            w[3:2] = 2'b11;
            send_word(w);
        end
        exit_load();

        // Asynchronous reset in the second ISSUE cycle
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        model_q.delete();
        check("arst_valid", int'(instr_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_proc_reset", int'(proc_reset), 0);
        check("arst_count", int'(load_count), 0);
        tick();
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_start_prst", int'(proc_reset), 0);
        check("empty_start_busy", int'(busy), 0);
        tick();
        check("empty_start_valid", int'(instr_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
